// File: rtl/aiv_pkg.sv
// Shared definitions for the AIV RGB sampler: line FSM encoding, default
// timing constants and fixed field widths.
package aiv_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_HSYNC = 2'd0,
        ST_BACKPORCH  = 2'd1,
        ST_ACTIVE     = 2'd2
    } line_state_t;

    // Default timing, in 81 MHz system clocks unless noted.
    localparam int DEF_PIX_NUM       = 16;    // pixel-rate numerator (MHz)
    localparam int DEF_PIX_DEN       = 81;    // clock-rate denominator (MHz)
    localparam int DEF_H_START       = 972;
    localparam int DEF_ACTIVE_PIXELS = 640;
    localparam int DEF_V_START       = 23;
    localparam int DEF_ACTIVE_LINES  = 256;
    localparam int DEF_HSYNC_MIN     = 162;
    localparam int DEF_VSYNC_THRESH  = 1620;
    localparam int DEF_LOCK_TIMEOUT  = 6480;

    // Rising edges between the raw csync fall and the top seeing hsync_pulse,
    // on top of HSYNC_MIN: two synchroniser stages plus the registered pulse.
    localparam int SYNC_STAGES      = 2;
    localparam int HSYNC_DETECT_LAG = SYNC_STAGES + 1;

    localparam int LINE_W = 9;    // line counter / pixel_y
    localparam int X_W    = 10;   // pixel index / pixel_x

endpackage

// File: rtl/aiv_sync_sep.sv
// Composite-sync pulse classifier. Measures every low pulse of the already
// synchronised csync and emits single-clock hsync, vsync and loss-of-sync
// strobes.
module aiv_sync_sep
    import aiv_pkg::*;
#(
    parameter int HSYNC_MIN    = DEF_HSYNC_MIN,
    parameter int VSYNC_THRESH = DEF_VSYNC_THRESH,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic csync_n,
    output logic hsync_pulse,
    output logic vsync_pulse,
    output logic timeout_pulse
);

    localparam int PULSE_W   = $clog2(VSYNC_THRESH + 1);
    localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT + 1);

    logic                 csync_n_d;
    logic [PULSE_W-1:0]   low_cnt;
    logic [PULSE_W-1:0]   low_cnt_next;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic [TIMEOUT_W-1:0] idle_cnt_next;
    logic                 fall;
    logic                 hs_hit;
    logic                 vs_hit;
    logic                 to_hit;

    // Next-state of the pulse-width and idle counters plus threshold crossings.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        fall          = 1'b0;
        low_cnt_next  = '0;
        idle_cnt_next = idle_cnt;
        hs_hit        = 1'b0;
        vs_hit        = 1'b0;
        to_hit        = 1'b0;

        fall = csync_n_d & ~csync_n;

        // Pulse width: restart at 1 on the falling edge, saturate while low.
        if (fall) begin
            low_cnt_next = PULSE_W'(1);
        end else if (!csync_n) begin
            low_cnt_next = (low_cnt == '1) ? low_cnt : low_cnt + 1'b1;
        end

        // Each threshold fires once, on the clock the count first reaches it.
        if (!csync_n) begin
            hs_hit = (low_cnt_next == PULSE_W'(HSYNC_MIN)) &&
                     (low_cnt != PULSE_W'(HSYNC_MIN));
            vs_hit = (low_cnt_next == PULSE_W'(VSYNC_THRESH)) &&
                     (low_cnt != PULSE_W'(VSYNC_THRESH));
        end

        // Clocks since the last falling edge, saturating at the timeout.
        if (fall) begin
            idle_cnt_next = '0;
        end else if (idle_cnt != TIMEOUT_W'(LOCK_TIMEOUT)) begin
            idle_cnt_next = idle_cnt + 1'b1;
            to_hit        = (idle_cnt_next == TIMEOUT_W'(LOCK_TIMEOUT));
        end
    end

    // Register counters and strobes; vsync wins over hsync on a shared clock.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            csync_n_d     <= 1'b0;
            low_cnt       <= '0;
            idle_cnt      <= '0;
            hsync_pulse   <= 1'b0;
            vsync_pulse   <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            csync_n_d     <= csync_n;
            low_cnt       <= low_cnt_next;
            idle_cnt      <= idle_cnt_next;
            hsync_pulse   <= hs_hit & ~vs_hit;
            vsync_pulse   <= vs_hit;
            timeout_pulse <= to_hit;
        end
    end

endmodule

// File: rtl/aiv_sampler.sv
// AIV TTL RGB sampler: synchronises the host RGB/csync, separates sync,
// locks to the field, and samples each active line at the pixel rate using a
// fractional phase accumulator.
module aiv_sampler
    import aiv_pkg::*;
#(
    parameter int PIX_NUM       = DEF_PIX_NUM,
    parameter int PIX_DEN       = DEF_PIX_DEN,
    parameter int H_START       = DEF_H_START,
    parameter int ACTIVE_PIXELS = DEF_ACTIVE_PIXELS,
    parameter int V_START       = DEF_V_START,
    parameter int ACTIVE_LINES  = DEF_ACTIVE_LINES,
    parameter int HSYNC_MIN     = DEF_HSYNC_MIN,
    parameter int VSYNC_THRESH  = DEF_VSYNC_THRESH,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        aiv_rgb_async,
    input  logic              aiv_csync_n_async,
    output logic [2:0]        rgb_111,
    output logic              pixel_valid,
    output logic [X_W-1:0]    pixel_x,
    output logic [LINE_W-1:0] pixel_y,
    output logic              line_start,
    output logic              field_start,
    output logic              locked
);

    localparam int ACC_W = $clog2(PIX_DEN + PIX_NUM);
    localparam int BP_W  = $clog2(H_START + 1);

    // Backporch counter value when hsync is recognised: the count of rising
    // edges already elapsed since the raw csync fell.
    localparam int BP_LOAD = HSYNC_MIN + HSYNC_DETECT_LAG;

    logic [2:0]        rgb_s1;
    logic [2:0]        rgb_s2;
    logic              csync_s1;
    logic              csync_s2;

    logic              hsync_pulse;
    logic              vsync_pulse;
    logic              timeout_pulse;

    line_state_t       state;
    logic [BP_W-1:0]   bp_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [X_W-1:0]    pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              vsync_seen;
    logic              take_sample;
    logic              line_active;

    // Two-flop synchronisers for the asynchronous host signals.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_s1   <= '0;
            rgb_s2   <= '0;
            csync_s1 <= 1'b0;
            csync_s2 <= 1'b0;
        end else begin
            rgb_s1   <= aiv_rgb_async;
            rgb_s2   <= rgb_s1;
            csync_s1 <= aiv_csync_n_async;
            csync_s2 <= csync_s1;
        end
    end

    aiv_sync_sep #(
        .HSYNC_MIN    (HSYNC_MIN),
        .VSYNC_THRESH (VSYNC_THRESH),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_sync_sep (
        .clk           (clk),
        .reset         (reset),
        .csync_n       (csync_s2),
        .hsync_pulse   (hsync_pulse),
        .vsync_pulse   (vsync_pulse),
        .timeout_pulse (timeout_pulse)
    );

    // Phase step, sample decision and vertical window.
    always_comb begin
        acc_sum     = acc + ACC_W'(PIX_NUM);
        take_sample = (state == ST_ACTIVE) && (acc_sum >= ACC_W'(PIX_DEN));
        line_active = (line_cnt >= LINE_W'(V_START)) &&
                      (line_cnt <= LINE_W'(V_START + ACTIVE_LINES - 1));
    end

    // Line FSM, sampler, line/field bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_HSYNC;
            bp_cnt      <= '0;
            acc         <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            vsync_seen  <= 1'b0;
            locked      <= 1'b0;
            rgb_111     <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            field_start <= 1'b0;
        end else begin
            // Strobes and the pixel bus fall back to zero unless a sample fires.
            line_start  <= 1'b0;
            field_start <= 1'b0;
            pixel_valid <= 1'b0;
            rgb_111     <= '0;

            case (state)
                ST_WAIT_HSYNC: begin
                    bp_cnt <= '0;
                end

                ST_BACKPORCH: begin
                    bp_cnt <= bp_cnt + 1'b1;
                    // Load half a pixel of phase so samples land mid-pixel.
                    if (bp_cnt == BP_W'(H_START - 1)) begin
                        state   <= ST_ACTIVE;
                        acc     <= ACC_W'(PIX_DEN / 2);
                        pix_cnt <= '0;
                    end
                end

                ST_ACTIVE: begin
                    if (take_sample) begin
                        acc     <= acc_sum - ACC_W'(PIX_DEN);
                        pix_cnt <= pix_cnt + 1'b1;
                        if (locked && line_active) begin
                            pixel_valid <= 1'b1;
                            rgb_111     <= rgb_s2;
                            pixel_x     <= pix_cnt;
                            pixel_y     <= line_cnt - LINE_W'(V_START);
                        end
                        if (pix_cnt == X_W'(ACTIVE_PIXELS - 1)) begin
                            state <= ST_WAIT_HSYNC;
                        end
                    end else begin
                        acc <= acc_sum;
                    end
                end

                default: begin
                    state <= ST_WAIT_HSYNC;
                end
            endcase

            // Sync events override the FSM; vsync takes precedence over hsync.
            if (vsync_pulse) begin
                field_start <= 1'b1;
                line_cnt    <= '0;
                vsync_seen  <= 1'b1;
            end else if (hsync_pulse) begin
                line_start <= 1'b1;
                line_cnt   <= (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;
                if (vsync_seen) begin
                    locked <= 1'b1;
                end
                // Any hsync, even mid-line, restarts the backporch count.
                state  <= ST_BACKPORCH;
                bp_cnt <= BP_W'(BP_LOAD);
            end

            // Loss of csync drops lock and forces a full vsync + hsync re-sync.
            if (timeout_pulse) begin
                locked     <= 1'b0;
                vsync_seen <= 1'b0;
                state      <= ST_WAIT_HSYNC;
            end
        end
    end

endmodule

// File: tb/tb_aiv_sampler.sv
// Directed bench for aiv_sampler: reset state, field lock, full active lines
// from a vector table, mid-line glitch, reset mid-line and loss-of-sync.
`timescale 1ns/1ps
module tb_aiv_sampler;

    localparam int H_START      = 972;
    localparam int LOCK_TIMEOUT = 6480;
    localparam int LINE_LEN     = 5184;
    localparam int HS_LOW       = 324;
    localparam int SHORT_LEN    = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] aiv_rgb_async;
    logic       aiv_csync_n_async;
    logic [2:0] rgb_111;
    logic       pixel_valid;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic       line_start;
    logic       field_start;
    logic       locked;

    aiv_sampler dut (
        .clk               (clk),
        .reset             (reset),
        .aiv_rgb_async     (aiv_rgb_async),
        .aiv_csync_n_async (aiv_csync_n_async),
        .rgb_111           (rgb_111),
        .pixel_valid       (pixel_valid),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .line_start        (line_start),
        .field_start       (field_start),
        .locked            (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Per-line statistics gathered on the falling edge.
    int         mon_count, mon_first, mon_last, gap_min, gap_max;
    int         x_err, y_err, rgb_err, idle_err, ls_count, fs_count;
    logic [8:0] exp_y;
    logic [2:0] exp_rgb;
    int         fall_cyc;

    always @(negedge clk) begin
        int gap;
        if (line_start)  ls_count++;
        if (field_start) fs_count++;
        if (pixel_valid) begin
            if (mon_count == 0) begin
                mon_first = cyc;
            end else begin
                gap = cyc - mon_last;
                if (gap < gap_min) gap_min = gap;
                if (gap > gap_max) gap_max = gap;
            end
            if (pixel_x != 10'(mon_count)) x_err++;
            if (pixel_y != exp_y)          y_err++;
            if (rgb_111 != exp_rgb)        rgb_err++;
            mon_last = cyc;
            mon_count++;
        end else if (rgb_111 != 3'b000) begin
            idle_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        mon_count = 0; mon_first = 0; mon_last = 0;
        gap_min = 1_000_000; gap_max = 0;
        x_err = 0; y_err = 0; rgb_err = 0; idle_err = 0;
        ls_count = 0; fs_count = 0;
    endtask

    // One csync line: low for 'low' clocks from the start, optional 100-clock
    // glitch at offset glitch_at, high for the rest of 'len' clocks.
    task automatic drive_line(input int len, input int low, input int glitch_at);
        clear_stats();
        for (int i = 0; i < len; i++) begin
            aiv_csync_n_async = !((i < low) ||
                                  (glitch_at > 0 && i >= glitch_at && i < glitch_at + 100));
            if (i == 0) fall_cyc = cyc;
            tick();
        end
    endtask

    typedef struct {
        logic [2:0] rgb;
        int         glitch_at;
        int         exp_count;
        int         exp_y;
        logic [2:0] exp_rgb;
        int         exp_ls;
    } line_vec_t;

    line_vec_t vecs [3];

    task automatic run_checked_line(input line_vec_t v, input string tag);
        exp_y         = 9'(v.exp_y);
        exp_rgb       = v.exp_rgb;
        aiv_rgb_async = v.rgb;
        drive_line(LINE_LEN, HS_LOW, v.glitch_at);
        check({tag, "_count"},      mon_count,            v.exp_count);
        check({tag, "_first_lat"},  mon_first - fall_cyc, H_START + 3);
        check({tag, "_gap_min"},    gap_min,              5);
        check({tag, "_gap_max"},    gap_max,              6);
        check({tag, "_x_seq_err"},  x_err,                0);
        check({tag, "_y_err"},      y_err,                0);
        check({tag, "_rgb_err"},    rgb_err,              0);
        check({tag, "_idle_rgb"},   idle_err,             0);
        check({tag, "_line_start"}, ls_count,             v.exp_ls);
    endtask

    // Vsync pulse followed by 22 short lines: the first short line locks and
    // the 23rd hsync after vsync (the next full line) is line V_START.
    task automatic sync_field(input string tag);
        drive_line(2200, 1700, 0);
        check({tag, "_field_start"}, fs_count, 1);
        check({tag, "_vs_line_start"}, ls_count, 1);
        check({tag, "_unlocked_after_vs"}, locked, 0);
        for (int l = 0; l < 22; l++) begin
            drive_line(SHORT_LEN, HS_LOW, 0);
            if (l == 0) check({tag, "_lock_first_hs"}, locked, 1);
        end
        check({tag, "_short_no_valid"}, mon_count, 0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int slot;
        int drop;

        vecs[0] = '{rgb: 3'b101, glitch_at: 0,    exp_count: 640, exp_y: 0, exp_rgb: 3'b101, exp_ls: 1};
        vecs[1] = '{rgb: 3'b010, glitch_at: 2000, exp_count: 640, exp_y: 1, exp_rgb: 3'b010, exp_ls: 1};
        vecs[2] = '{rgb: 3'b111, glitch_at: 0,    exp_count: 640, exp_y: 2, exp_rgb: 3'b111, exp_ls: 1};

        clear_stats();
        exp_y = '0; exp_rgb = '0;
        reset = 1'b1;
        aiv_rgb_async = 3'b000;
        aiv_csync_n_async = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("rst_rgb",         rgb_111,     0);
        check("rst_valid",       pixel_valid, 0);
        check("rst_x",           pixel_x,     0);
        check("rst_y",           pixel_y,     0);
        check("rst_line_start",  line_start,  0);
        check("rst_field_start", field_start, 0);
        check("rst_locked",      locked,      0);

        // Field lock, then three full active lines from the table.
        sync_field("f1");
        run_checked_line(vecs[0], "l23");
        run_checked_line(vecs[1], "l24_glitch");
        run_checked_line(vecs[2], "l25");

        // Reset just before the sample that follows pixel 300.
        exp_y = 9'd3; exp_rgb = 3'b101; aiv_rgb_async = 3'b101;
        clear_stats();
        slot = 0;
        while (slot < LINE_LEN && mon_count < 300) begin
            aiv_csync_n_async = !(slot < HS_LOW);
            if (slot == 0) fall_cyc = cyc;
            tick();
            slot++;
        end
        check("pre_reset_count", mon_count, 300);
        aiv_csync_n_async = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("reset_valid_drop", pixel_valid, 0);
        check("reset_x_cleared",  pixel_x,     0);
        check("reset_locked",     locked,      0);
        tick();
        reset = 1'b0;
        check("reset_no_extra",   mon_count,   300);

        // Hsync alone after reset must not produce pixels.
        drive_line(LINE_LEN, HS_LOW, 0);
        check("post_reset_no_valid", mon_count, 0);
        check("post_reset_unlocked", locked,    0);
        check("post_reset_hs",       ls_count,  1);

        // Re-sync and confirm sampling resumes on line V_START.
        sync_field("f2");
        run_checked_line(vecs[0], "resync_l23");

        // Loss of csync: locked must fall after the idle timeout.
        check("locked_before_idle", locked, 1);
        drop = -1;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (!locked) begin
                drop = cyc - fall_cyc;
                break;
            end
        end
        check_range("timeout_delay", drop, LOCK_TIMEOUT, LOCK_TIMEOUT + 8);

        // Line counter is now in the active window, but lock is gone.
        exp_y = 9'd1; exp_rgb = 3'b101;
        drive_line(LINE_LEN, HS_LOW, 0);
        check("timeout_no_valid", mon_count, 0);
        check("timeout_unlocked", locked,    0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
